// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8E1/8O1/8x2 UART transmitter: valid/ready byte FIFO feeding a serialiser.
// Start bit leaves 2 edges after a push into an idle block; tx_ready is a registered !full.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          FPGA_CLK,
    input  logic                          RESET_BUT,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          UART_TXD,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            ready_q, ready_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push, pop, baud_tick, fifo_nempty;

    assign push        = tx_valid & ready_q;
    assign baud_tick   = (baud_cnt_q == DIV_LAST);
    assign fifo_nempty = (count_q != '0);

    always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
        if (RESET_BUT) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    // Next state; STOP chains straight into START so queued frames have no idle gap.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_tick ? '0 : baud_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (fifo_nempty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        if (fifo_nempty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[bit_cnt_q];
            PARITY:  txd_d = (^shift_q) ^ PAR_ODD;
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
    end

    assign tx_ready   = ready_q;
    assign UART_TXD   = txd_q;
    assign tx_busy    = (state_q != IDLE) || fifo_nempty;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameterisations, line checked against a frame model built from bytes.
module tb_uart_tx_fifo;
    localparam int DEF_DIV = (50_000_000 + 115200 / 2) / 115200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dat  [4];
    logic       vld  [4];
    logic       rdy  [4];
    logic       txd  [4];
    logic       busy [4];
    logic [2:0] cnt  [4];
    int div_t [4];
    int pen_t [4];
    int podd_t[4];
    int nstop_t[4];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(115200), .FIFO_DEPTH(4),
                   .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
        .FPGA_CLK(clk), .RESET_BUT(rst), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .UART_TXD(txd[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(115200), .FIFO_DEPTH(4),
                   .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_even2 (
        .FPGA_CLK(clk), .RESET_BUT(rst), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .UART_TXD(txd[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(115200), .FIFO_DEPTH(4),
                   .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd1 (
        .FPGA_CLK(clk), .RESET_BUT(rst), .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .UART_TXD(txd[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(4),
                   .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_slow (
        .FPGA_CLK(clk), .RESET_BUT(rst), .tx_data(dat[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
        .UART_TXD(txd[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input int k, input logic [7:0] b);
        int   w = 0;
        logic acc;
        dat[k] = b;
        vld[k] = 1'b1;
        do begin
            acc = rdy[k];
            tick();
            w++;
        end while (!acc && w < 10000);
        vld[k] = 1'b0;
        n_checks++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept inst %0d: not accepted after %0d cycles, required accept", k, w);
        end
    endtask

    // Expected line per frame: start, D0..D7, optional parity, stop run of STOP_BITS*div cycles.
    task automatic check_frames(input int k, input logic [7:0] bytes[$], input bit allow_gap,
                                output logic busy_prev, output logic busy_last);
        int div = div_t[k];
        busy_prev = 1'b0;
        busy_last = 1'b1;
        for (int f = 0; f < bytes.size(); f++) begin
            logic [7:0] b;
            logic       segv[$];
            int         segl[$];
            int         w;
            b = bytes[f];
            segv = {};
            segl = {};
            w = 0;
            segv.push_back(1'b0); segl.push_back(div);
            for (int i = 0; i < 8; i++) begin
                segv.push_back(b[i]); segl.push_back(div);
            end
            if (pen_t[k] != 0) begin
                segv.push_back((^b) ^ (podd_t[k] != 0)); segl.push_back(div);
            end
            segv.push_back(1'b1); segl.push_back(nstop_t[k] * div);
            if (f > 0) tick();
            if (f == 0 || allow_gap) begin
                while (txd[k] !== 1'b0 && w < 20000) begin
                    tick();
                    w++;
                end
                n_checks++;
                if (txd[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_wait inst %0d frame %0d: line %b after %0d cycles, required 0", k, f, txd[k], w);
                    return;
                end
            end
            for (int j = 0; j < segv.size(); j++) begin
                int   bad = 0;
                logic got = segv[j];
                for (int c = 0; c < segl[j]; c++) begin
                    if (j > 0 || c > 0) tick();
                    if (txd[k] !== segv[j]) begin
                        bad++;
                        got = txd[k];
                    end
                    if (f == bytes.size() - 1 && j == segv.size() - 1) begin
                        if (c == segl[j] - 2) busy_prev = busy[k];
                        if (c == segl[j] - 1) busy_last = busy[k];
                    end
                end
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL line_bit inst %0d frame %0d seg %0d: %0d of %0d cycles got %b, required %b",
                             k, f, j, bad, segl[j], got, segv[j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            n_checks += 4;
            if (txd[k]  !== 1'b1) begin n_fail++; $display("FAIL rst_txd inst %0d: got %b required 1", k, txd[k]); end
            if (rdy[k]  !== 1'b0) begin n_fail++; $display("FAIL rst_ready inst %0d: got %b required 0", k, rdy[k]); end
            if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL rst_busy inst %0d: got %b required 0", k, busy[k]); end
            if (cnt[k]  !== 3'd0) begin n_fail++; $display("FAIL rst_count inst %0d: got %0d required 0", k, cnt[k]); end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b required 0", rdy[0]); end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rdy[k] !== 1'b1) begin n_fail++; $display("FAIL ready_after_release inst %0d: got %b required 1", k, rdy[k]); end
        end
    endtask

    task automatic test_single();
        logic [7:0] q[$];
        logic       bp, bl;
        q = '{8'h55};
        push_byte(0, 8'h55);
        n_checks += 2;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b required 1", busy[0]); end
        if (cnt[0] !== 3'd1) begin n_fail++; $display("FAIL count_one: got %0d required 1", cnt[0]); end
        tick();
        n_checks++;
        if (txd[0] !== 1'b1) begin n_fail++; $display("FAIL start_early: got %b required 1", txd[0]); end
        tick();
        n_checks++;
        if (txd[0] !== 1'b0) begin n_fail++; $display("FAIL start_2nd_edge: got %b required 0", txd[0]); end
        check_frames(0, q, 1'b0, bp, bl);
        n_checks += 3;
        if (bp !== 1'b1) begin n_fail++; $display("FAIL busy_before_end: got %b required 1", bp); end
        if (bl !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b required 0", bl); end
        if (cnt[0] !== 3'd0) begin n_fail++; $display("FAIL count_empty: got %0d required 0", cnt[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic       bp, bl;
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fork
            begin
                int   nxt = 1;
                int   cyc = 0;
                int   w = 0;
                logic acc;
                dat[0] = 8'h01;
                vld[0] = 1'b1;
                while (nxt <= 5 && w < 100) begin
                    acc = rdy[0];
                    tick();
                    w++;
                    if (nxt > 1) cyc++;
                    if (acc) begin
                        nxt++;
                        dat[0] = 8'(nxt);
                    end
                end
                vld[0] = 1'b0;
                n_checks += 4;
                if (nxt != 6) begin n_fail++; $display("FAIL b2b_accepted: got %0d required 5", nxt - 1); end
                if (cyc != 4) begin n_fail++; $display("FAIL b2b_accept_span: got %0d required 4", cyc); end
                if (cnt[0] !== 3'd4) begin n_fail++; $display("FAIL b2b_full_count: got %0d required 4", cnt[0]); end
                if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b required 0", rdy[0]); end
                w = 0;
                while (rdy[0] !== 1'b1 && w < 10000) begin
                    tick();
                    cyc++;
                    w++;
                end
                n_checks += 2;
                if (cyc != 1 + 10 * DEF_DIV) begin n_fail++; $display("FAIL b2b_ready_rise: got cycle %0d required %0d", cyc, 1 + 10 * DEF_DIV); end
                if (cnt[0] !== 3'd3) begin n_fail++; $display("FAIL b2b_count_after_pop: got %0d required 3", cnt[0]); end
            end
            begin
                check_frames(0, q, 1'b0, bp, bl);
            end
        join
        n_checks += 2;
        if (bl !== 1'b0 || bp !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_end: got %b%b required 10", bp, bl); end
        if (cnt[0] !== 3'd0) begin n_fail++; $display("FAIL b2b_count_end: got %0d required 0", cnt[0]); end
    endtask

    task automatic test_parity();
        for (int k = 1; k <= 2; k++) begin
            logic [7:0] q[$];
            logic       bp, bl;
            logic [7:0] r;
            r = 8'($urandom);
            q = '{8'h07, r};
            push_byte(k, 8'h07);
            push_byte(k, r);
            check_frames(k, q, 1'b0, bp, bl);
            n_checks++;
            if (bl !== 1'b0) begin n_fail++; $display("FAIL parity_busy_end inst %0d: got %b required 0", k, bl); end
        end
    endtask

    task automatic test_same_edge();
        logic [7:0] q[$];
        logic       bp, bl;
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        fork
            begin
                push_byte(3, q[0]);
                dat[3] = q[1]; vld[3] = 1'b1;
                tick();
                dat[3] = q[2];
                tick();
                vld[3] = 1'b0;
                n_checks++;
                if (cnt[3] !== 3'd2) begin n_fail++; $display("FAIL se_count_pre: got %0d required 2", cnt[3]); end
                repeat (78) tick();
                n_checks += 2;
                if (cnt[3] !== 3'd2) begin n_fail++; $display("FAIL se_count_hold: got %0d required 2", cnt[3]); end
                if (rdy[3] !== 1'b1) begin n_fail++; $display("FAIL se_ready: got %b required 1", rdy[3]); end
                dat[3] = q[3]; vld[3] = 1'b1;
                tick();
                vld[3] = 1'b0;
                n_checks++;
                if (cnt[3] !== 3'd2) begin n_fail++; $display("FAIL se_push_pop_count: got %0d required 2", cnt[3]); end
            end
            begin
                check_frames(3, q, 1'b0, bp, bl);
            end
        join
        n_checks++;
        if (bl !== 1'b0 || cnt[3] !== 3'd0) begin n_fail++; $display("FAIL se_end: busy %b count %0d required 0 0", bl, cnt[3]); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int         gaps[$];
        logic       bp, bl;
        int         n;
        n = $urandom_range(12, 6);
        for (int i = 0; i < n; i++) begin
            q.push_back(8'($urandom));
            gaps.push_back(($urandom_range(3, 0) == 0) ? $urandom_range(140, 100) : $urandom_range(2, 0));
        end
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    repeat (gaps[i]) tick();
                    push_byte(3, q[i]);
                end
            end
            begin
                check_frames(3, q, 1'b1, bp, bl);
            end
        join
        n_checks++;
        if (bl !== 1'b0 || cnt[3] !== 3'd0) begin n_fail++; $display("FAIL rnd_end: busy %b count %0d required 0 0", bl, cnt[3]); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] a;
        int         bad_txd = 0;
        int         bad_busy = 0;
        a = 8'($urandom) & 8'hF7;
        push_byte(0, a);
        dat[0] = 8'($urandom); vld[0] = 1'b1;
        tick();
        dat[0] = 8'($urandom);
        tick();
        vld[0] = 1'b0;
        n_checks++;
        if (cnt[0] !== 3'd2) begin n_fail++; $display("FAIL mid_queued: got %0d required 2", cnt[0]); end
        repeat (4 * DEF_DIV + DEF_DIV / 2) tick();
        n_checks++;
        if (txd[0] !== 1'b0) begin n_fail++; $display("FAIL mid_bit3_low: got %b required 0", txd[0]); end
        #1 rst = 1'b1;
        #1;
        n_checks += 4;
        if (txd[0]  !== 1'b1) begin n_fail++; $display("FAIL mid_rst_txd: got %b required 1", txd[0]); end
        if (cnt[0]  !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d required 0", cnt[0]); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b required 0", busy[0]); end
        if (rdy[0]  !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b required 0", rdy[0]); end
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (txd[0] !== 1'b1) bad_txd++;
            if (busy[0] !== 1'b0) bad_busy++;
        end
        n_checks += 3;
        if (bad_txd != 0)  begin n_fail++; $display("FAIL mid_post_line: %0d cycles not idle, required 0", bad_txd); end
        if (bad_busy != 0) begin n_fail++; $display("FAIL mid_post_busy: %0d cycles busy, required 0", bad_busy); end
        if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_post_ready: got %b required 1", rdy[0]); end
    endtask

    initial begin
        rst = 1'b1;
        div_t   = '{DEF_DIV, DEF_DIV, DEF_DIV, 8};
        pen_t   = '{0, 1, 1, 0};
        podd_t  = '{0, 0, 1, 0};
        nstop_t = '{1, 2, 1, 1};
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            dat[k] = 8'h00;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_same_edge();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
